int_seq_carry_adder: RTL and testbench
======================================

INT_SEQ_CARRY_ADDER -- requirements
Module: int_seq_carry_adder

Interface
REQ-001 Parameter DATA_WIDTH, default 32: operand and result width in bits.
REQ-002 Parameter SLICE_WIDTH, default 8: bits processed per RUN cycle; DATA_WIDTH SHALL be an integer multiple of SLICE_WIDTH, otherwise elaboration fails. NSL = DATA_WIDTH/SLICE_WIDTH.
REQ-003 Parameter EARLY_EXIT, default 0: 1 enables carry-termination shortcut.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  input  1  clock; all state changes on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  operand request valid.
REQ-008 in_ready  output  1  block can accept operand.
REQ-009 data_in  input  DATA_WIDTH  operand.
REQ-010 carry_in  input  1  carry/borrow in.
REQ-011 mode  input  2  00 data+cin; 01 ~data+1 (negate); 10 data-cin; 11 ~data+cin.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 sum  output  DATA_WIDTH  result.
REQ-015 carry_out  output  1  carry out of MSB (modes 00/01/11); borrow out of MSB (mode 10).

Function
REQ-016 FSM states IDLE, RUN, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-017 IDLE: in_valid&in_ready captures data_in, carry_in, mode; slice index := 0; internal carry := carry_in (mode 01: 1); -> RUN.
REQ-018 RUN: each cycle computes one SLICE_WIDTH slice, LSB slice first, of operand (data_in for 00/10, ~data_in for 01/11) plus carry (minus borrow for mode 10); writes slice into result register; updates internal carry/borrow; index +1.
REQ-019 RUN -> DONE after slice NSL-1; carry_out := final carry/borrow.
REQ-020 EARLY_EXIT=1: if internal carry/borrow is 0 after any slice, all higher slices are filled with the operand unchanged, carry_out := 0, -> DONE on that same edge.
REQ-021 Latency: out_valid rises NSL edges after accepting edge (EARLY_EXIT=0); j edges if early exit triggers after slice j (1 <= j <= NSL).
REQ-022 DONE: sum and carry_out held stable while out_valid & !out_ready; out_valid&out_ready -> IDLE.
REQ-023 No new operand accepted in RUN or DONE; in_valid ignored there; no same-cycle turnaround from DONE to accept.
REQ-024 mode, data_in, carry_in only sampled at acceptance; changes during RUN/DONE have no effect.
REQ-025 Arithmetic is modulo 2^DATA_WIDTH; result bit-exact with combinational ripple equivalent of the selected mode.
REQ-026 sum and carry_out read 0 in IDLE after reset; after handshake they retain last result until next RUN overwrites them.

Reset
REQ-027 rst high at a rising edge forces IDLE, sum := 0, carry_out := 0, slice index := 0, internal carry := 0, regardless of state.
REQ-028 Reset in RUN or DONE aborts the operation; no out_valid produced for it; in_ready = 1 in the cycle after rst deasserts.
REQ-029 rst has priority over in_valid and out_ready in the same cycle.

Verification (DATA_WIDTH=32, SLICE_WIDTH=8)
REQ-030 EARLY_EXIT=0, mode 00, data 0x000000FF, cin 1 -> sum 0x00000100, carry_out 0, out_valid 4 edges after accept.
REQ-031 mode 00, data 0xFFFFFFFF, cin 1, EARLY_EXIT=1 -> sum 0x00000000, carry_out 1, still 4 edges; same data with cin 0 -> sum 0xFFFFFFFF, carry_out 0 after 1 edge.
REQ-032 mode 01, data 0x00000005 -> sum 0xFFFFFFFB, carry_out 0; data 0x00000000 -> sum 0, carry_out 1.
REQ-033 mode 10, data 0x00000000, cin 1 -> sum 0xFFFFFFFF, carry_out 1; data 0x00000100, cin 1, EARLY_EXIT=1 -> sum 0x000000FF, carry_out 0, 2 edges.
REQ-034 Result pending, out_ready low 5 cycles, in_valid pulsed -> sum/carry_out stable, in_ready 0, pulse ignored; out_ready high -> IDLE next edge.
REQ-035 rst pulsed during 2nd RUN cycle -> out_valid never rises for that operand, sum 0, in_ready 1 next cycle; following operand completes correctly.

Source files
------------

// File: rtl/int_seq_carry_adder.sv
// Sequential slice-serial adder: one SLICE_WIDTH slice per cycle, LSB first,
// with optional carry-termination early exit. Valid/ready on both sides.
module int_seq_carry_adder #(
  parameter int DATA_WIDTH  = 32,
  parameter int SLICE_WIDTH = 8,
  parameter int EARLY_EXIT  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  carry_in,
  input  logic [1:0]            mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  carry_out
);
  localparam int NSL = DATA_WIDTH / SLICE_WIDTH;
  localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;

  generate
    if (DATA_WIDTH % SLICE_WIDTH != 0) begin : g_bad_width
      $error("DATA_WIDTH must be a multiple of SLICE_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   op_r, sum_r, sum_nxt;
  logic                    sub_r, carry_r, cout_r;
  logic [IW-1:0]           idx;

  logic [SLICE_WIDTH-1:0]  slice, slice_sum;
  logic [SLICE_WIDTH:0]    add_res, sub_res;
  logic                    carry_nxt, last, exit_now, finish;

  assign slice     = op_r[idx*SLICE_WIDTH +: SLICE_WIDTH];
  assign add_res   = {1'b0, slice} + {{SLICE_WIDTH{1'b0}}, carry_r};
  // Borrow falls out as the extra MSB of the widened subtraction.
  assign sub_res   = {1'b0, slice} - {{SLICE_WIDTH{1'b0}}, carry_r};
  assign slice_sum = sub_r ? sub_res[SLICE_WIDTH-1:0] : add_res[SLICE_WIDTH-1:0];
  assign carry_nxt = sub_r ? sub_res[SLICE_WIDTH] : add_res[SLICE_WIDTH];
  assign last      = (idx == IW'(NSL-1));
  assign exit_now  = (EARLY_EXIT != 0) && !carry_nxt;
  assign finish    = last || exit_now;

  // Current slice gets the computed bits; on early exit, the upper slices
  // are simply the operand since no carry propagates into them.
  always_comb begin
    sum_nxt = sum_r;
    for (int k = 0; k < NSL; k++) begin
      if (k == int'(idx))
        sum_nxt[k*SLICE_WIDTH +: SLICE_WIDTH] = slice_sum;
      else if (exit_now && k > int'(idx))
        sum_nxt[k*SLICE_WIDTH +: SLICE_WIDTH] = op_r[k*SLICE_WIDTH +: SLICE_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (finish)    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_r    <= '0;
      sub_r   <= 1'b0;
      carry_r <= 1'b0;
      idx     <= '0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_r    <= mode[0] ? ~data_in : data_in;
          sub_r   <= (mode == 2'b10);
          carry_r <= (mode == 2'b01) ? 1'b1 : carry_in;
          idx     <= '0;
        end
        RUN: begin
          sum_r   <= sum_nxt;
          carry_r <= carry_nxt;
          idx     <= idx + 1'b1;
          if (finish) cout_r <= carry_nxt;
        end
        default: ;
      endcase
    end
  end

  assign sum       = sum_r;
  assign carry_out = cout_r;
endmodule

// File: tb/tb_int_seq_carry_adder.sv
// Bench for int_seq_carry_adder: EARLY_EXIT=0 and =1 instances share stimulus,
// results checked against a whole-word arithmetic model.
module tb_int_seq_carry_adder;
  localparam int DW = 32, SW = 8, NSL = DW/SW;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, carry_in = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [1:0] mode = 2'b00;
  logic ir0, ir1, ov0, ov1, co0, co1;
  logic [DW-1:0] s0, s1;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  int_seq_carry_adder #(.DATA_WIDTH(DW), .SLICE_WIDTH(SW), .EARLY_EXIT(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .data_in(data_in),
    .carry_in(carry_in), .mode(mode), .out_valid(ov0), .out_ready(out_ready),
    .sum(s0), .carry_out(co0));
  int_seq_carry_adder #(.DATA_WIDTH(DW), .SLICE_WIDTH(SW), .EARLY_EXIT(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .data_in(data_in),
    .carry_in(carry_in), .mode(mode), .out_valid(ov1), .out_ready(out_ready),
    .sum(s1), .carry_out(co1));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Whole-word reference: result, carry/borrow out, and early-exit latency.
  task automatic model(input logic [1:0] m, input logic [DW-1:0] d, input logic c,
                       output logic [DW-1:0] rs, output logic rc, output int lat_ee);
    logic [DW-1:0] op;
    logic [DW:0] r;
    logic cin_eff;
    longint unsigned low, mask;
    op      = (m == 2'b01 || m == 2'b11) ? ~d : d;
    cin_eff = (m == 2'b01) ? 1'b1 : c;
    if (m == 2'b10) r = {1'b0, op} - {{DW{1'b0}}, cin_eff};
    else            r = {1'b0, op} + {{DW{1'b0}}, cin_eff};
    rs = r[DW-1:0];
    rc = r[DW];
    lat_ee = NSL;
    for (int j = 1; j <= NSL; j++) begin
      mask = (64'd1 << (SW*j)) - 1;
      low  = longint'(op) & mask;
      if (m == 2'b10) begin
        if (!(low < longint'(cin_eff))) begin lat_ee = j; break; end
      end else begin
        if (((low + longint'(cin_eff)) >> (SW*j)) == 0) begin lat_ee = j; break; end
      end
    end
  endtask

  task automatic accept(input logic [1:0] m, input logic [DW-1:0] d, input logic c);
    mode = m; data_in = d; carry_in = c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    data_in = $urandom; mode = 2'($urandom); carry_in = 1'($urandom);
  endtask

  // Returns edges until each instance shows out_valid (0 = never within bound).
  task automatic wait_done(output int l0, output int l1);
    l0 = 0; l1 = 0;
    for (int cyc = 1; cyc <= NSL + 4; cyc++) begin
      @(posedge clk); #1;
      if (l0 == 0 && ov0) l0 = cyc;
      if (l1 == 0 && ov1) l1 = cyc;
      if (l0 != 0 && l1 != 0) break;
    end
  endtask

  task automatic do_op(input string tag, input logic [1:0] m, input logic [DW-1:0] d, input logic c);
    logic [DW-1:0] es; logic ec; int ell, l0, l1;
    model(m, d, c, es, ec, ell);
    accept(m, d, c);
    wait_done(l0, l1);
    check({tag, " lat0"}, l0, NSL);
    check({tag, " lat1"}, l1, ell);
    check({tag, " sum0"}, s0, es);
    check({tag, " sum1"}, s1, es);
    check({tag, " cout0"}, co0, ec);
    check({tag, " cout1"}, co1, ec);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " idle"}, {ir0, ir1, ov0, ov1}, 4'b1100);
    check({tag, " retain"}, {s1, s0}, {es, es});
  endtask

  initial begin
    logic [DW-1:0] hs; logic hc; int l0, l1;
    repeat (2) @(posedge clk);
    #1;
    check("reset state", {ir0, ir1, ov0, ov1, co0, co1}, 6'b110000);
    check("reset sum", {s1, s0}, 64'd0);
    rst = 1'b0;

    do_op("add_ff", 2'b00, 32'h000000FF, 1'b1);
    do_op("add_all1_c1", 2'b00, 32'hFFFFFFFF, 1'b1);
    do_op("add_all1_c0", 2'b00, 32'hFFFFFFFF, 1'b0);
    do_op("neg5", 2'b01, 32'h00000005, 1'b0);
    do_op("neg0", 2'b01, 32'h00000000, 1'b1);
    do_op("sub_0", 2'b10, 32'h00000000, 1'b1);
    do_op("sub_100", 2'b10, 32'h00000100, 1'b1);
    do_op("inv_c1", 2'b11, 32'h00FF0000, 1'b1);
    do_op("inv_c0", 2'b11, 32'h12345678, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [DW-1:0] d;
      d = $urandom;
      if (i % 4 == 1) d = d | 32'h00FFFFFF;
      if (i % 4 == 2) d = d & 32'hFF000000;
      do_op("rand", 2'($urandom), d, 1'($urandom));
    end

    // Back-pressure: result held while out_ready low, input pulse ignored.
    accept(2'b00, 32'hDEADBEEF, 1'b1);
    wait_done(l0, l1);
    check("hold lat0", l0, NSL);
    hs = s0; hc = co0;
    check("hold value", {hc, hs}, {1'b0, 32'hDEADBEF0});
    for (int k = 0; k < 5; k++) begin
      in_valid = (k == 2); data_in = $urandom;
      @(posedge clk); #1;
      check("hold stable", {ov0, ir0, co0, s0}, {1'b1, 1'b0, hc, hs});
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hold release", {ir0, ir1, ov0, ov1}, 4'b1100);
    @(posedge clk); #1;
    check("pulse ignored", {ir0, ir1}, 2'b11);

    // Reset in second RUN cycle aborts the operation.
    accept(2'b00, 32'hFFFFFFFF, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort state", {ir0, ir1, ov0, ov1, co0, co1}, 6'b110000);
    check("abort sum", {s1, s0}, 64'd0);
    begin
      bit seen = 0;
      for (int k = 0; k < NSL + 2; k++) begin
        @(posedge clk); #1;
        if (ov0 || ov1) seen = 1;
      end
      check("abort no valid", seen, 1'b0);
    end
    do_op("post_abort", 2'b10, 32'h80000000, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
